// File: rtl/tiger_key_schedule_if.sv
// rtl/tiger_key_schedule_if.sv - handshake bundle between the pass controller, key schedule and round datapath
interface tiger_key_schedule_if;
  logic         i_valid;
  logic         o_ready;
  logic [511:0] i_x;
  logic         o_valid;
  logic         i_ready;
  logic [511:0] o_x;
  logic         o_busy;

  modport master (
    output i_valid, i_x, i_ready,
    input  o_ready, o_valid, o_x, o_busy
  );

  modport slave (
    input  i_valid, i_x, i_ready,
    output o_ready, o_valid, o_x, o_busy
  );
endinterface

// File: rtl/tiger_key_schedule.sv
// rtl/tiger_key_schedule.sv - iterative Tiger key schedule, one step per clock (16 steps)
// Define TIGER_KS_2STEP_EN to chain two steps per clock (8-cycle latency, identical results).
module tiger_key_schedule #(
  parameter logic [63:0] KS_C0 = 64'hA5A5A5A5A5A5A5A5,
  parameter logic [63:0] KS_C1 = 64'h0123456789ABCDEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tiger_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef logic [7:0][63:0] words_t;

`ifdef TIGER_KS_2STEP_EN
  localparam logic [3:0] CNT_INC  = 4'd2;
  localparam logic [3:0] CNT_LAST = 4'd14;
`else
  localparam logic [3:0] CNT_INC  = 4'd1;
  localparam logic [3:0] CNT_LAST = 4'd15;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  words_t     x_q, x_d;

  // Each step rewrites exactly one word, reading values already updated by earlier steps.
  function automatic words_t ks_step(input logic [3:0] idx, input words_t w);
    words_t r;
    r = w;
    case (idx)
      4'd0:  r[0] = w[0] - (w[7] ^ KS_C0);
      4'd1:  r[1] = w[1] ^ w[0];
      4'd2:  r[2] = w[2] + w[1];
      4'd3:  r[3] = w[3] - (w[2] ^ ((~w[1]) << 19));
      4'd4:  r[4] = w[4] ^ w[3];
      4'd5:  r[5] = w[5] + w[4];
      4'd6:  r[6] = w[6] - (w[5] ^ ((~w[4]) >> 23));
      4'd7:  r[7] = w[7] ^ w[6];
      4'd8:  r[0] = w[0] + w[7];
      4'd9:  r[1] = w[1] - (w[0] ^ ((~w[7]) << 19));
      4'd10: r[2] = w[2] ^ w[1];
      4'd11: r[3] = w[3] + w[2];
      4'd12: r[4] = w[4] - (w[3] ^ ((~w[2]) >> 23));
      4'd13: r[5] = w[5] ^ w[4];
      4'd14: r[6] = w[6] + w[5];
      4'd15: r[7] = w[7] - (w[6] ^ KS_C1);
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          x_d     = bus.i_x;
          cnt_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef TIGER_KS_2STEP_EN
        x_d = ks_step(cnt_q | 4'd1, ks_step(cnt_q, x_q));
`else
        x_d = ks_step(cnt_q, x_q);
`endif
        cnt_d = cnt_q + CNT_INC;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers double as the output register; they only move outside DONE.
  assign bus.o_x     = x_q;
  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q == CALC);

endmodule
